hack_screen_scanout: RTL and testbench

Video scanout stage directly downstream of the VRAM block. Generates 640x480@60 Hz VGA timing from a 25.175 MHz pixel clock. Reads the 512x256 monochrome Hack screen map, 8192 16-bit words, out of VRAM through its synchronous read port. Serialises the map into a centred pixel stream with a black border.

---
 rtl/video_pkg.sv | 38 +++
 rtl/vga_timing.sv | 42 ++++
 rtl/hack_screen_scanout.sv | 120 ++++++++++++
 tb/tb_hack_screen_scanout.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared 640x480@60 VGA timing constants and Hack screen geometry.
package video_pkg;

    typedef logic [9:0] count_t;

    localparam int DATA_W = 16;

    localparam count_t H_VISIBLE = 10'd640;
    localparam count_t H_FRONT   = 10'd16;
    localparam count_t H_SYNC    = 10'd96;
    localparam count_t H_BACK    = 10'd48;
    localparam count_t H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam count_t V_VISIBLE = 10'd480;
    localparam count_t V_FRONT   = 10'd10;
    localparam count_t V_SYNC    = 10'd2;
    localparam count_t V_BACK    = 10'd33;
    localparam count_t V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam count_t H_SYNC_FIRST = H_VISIBLE + H_FRONT;
    localparam count_t H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 10'd1;
    localparam count_t V_SYNC_FIRST = V_VISIBLE + V_FRONT;
    localparam count_t V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 10'd1;
    localparam count_t H_LAST       = H_TOTAL - 10'd1;
    localparam count_t V_LAST       = V_TOTAL - 10'd1;

    localparam int SCREEN_W      = 512;
    localparam int SCREEN_H      = 256;
    localparam int WORDS_PER_ROW = 32;

    // Address is issued this many cycles ahead of the word's first pixel.
    localparam int FETCH_LEAD = 3;

    function automatic logic in_range(input count_t c, input count_t lo, input count_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 800x525 raster counters with registered sync, display-enable and frame-start decode.
module vga_timing
    import video_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    output count_t hcount,
    output count_t vcount,
    output logic   hsync,
    output logic   vsync,
    output logic   de,
    output logic   frame_start
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    // Output stage: decode of the current counter value, visible one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !in_range(hcount, H_SYNC_FIRST, H_SYNC_LAST);
            vsync       <= !in_range(vcount, V_SYNC_FIRST, V_SYNC_LAST);
            de          <= (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
            frame_start <= (hcount == '0) && (vcount == '0);
        end
    end

endmodule

// File: rtl/hack_screen_scanout.sv
// Scans the 512x256 Hack screen map out of VRAM into a centred 640x480 VGA pixel stream.
module hack_screen_scanout
    import video_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR = 14'h0000,
    parameter int          X0        = 64,
    parameter int          Y0        = 112
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loaded,
    input  logic [DATA_W-1:0] vram_data,
    output logic [13:0]       vram_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              pixel,
    output logic              frame_start
);

    localparam count_t WIN_X_FIRST = count_t'(X0);
    localparam count_t WIN_X_LAST  = count_t'(X0 + SCREEN_W - 1);
    localparam count_t WIN_Y_FIRST = count_t'(Y0);
    localparam count_t WIN_Y_LAST  = count_t'(Y0 + SCREEN_H - 1);
    localparam count_t FETCH_FIRST = count_t'(X0 - FETCH_LEAD);
    localparam count_t FETCH_LAST  = count_t'(X0 + (WORDS_PER_ROW - 1) * 16 - FETCH_LEAD);

    count_t            hcount;
    count_t            vcount;
    logic              enable;
    logic              vld_p1;
    logic              vld_p2;
    logic [DATA_W-1:0] word_buf;
    logic [DATA_W-1:0] shift;

    logic [3:0] sx_lo;
    logic [7:0] sy_lo;
    logic [8:0] fetch_off;
    logic       win_v;
    logic       win;
    logic       visible;
    logic       fetch_p0;
    logic       frame_wrap;
    logic       pix_bit;

    vga_timing u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start)
    );

    // Only the low bits of the window-relative coordinates are ever needed.
    assign sx_lo      = hcount[3:0] - WIN_X_FIRST[3:0];
    assign sy_lo      = vcount[7:0] - WIN_Y_FIRST[7:0];
    assign fetch_off  = hcount[8:0] - FETCH_FIRST[8:0];
    assign win_v      = in_range(vcount, WIN_Y_FIRST, WIN_Y_LAST);
    assign win        = enable && win_v && in_range(hcount, WIN_X_FIRST, WIN_X_LAST);
    assign visible    = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
    assign fetch_p0   = enable && win_v && in_range(hcount, FETCH_FIRST, FETCH_LAST)
                        && (fetch_off[3:0] == 4'd0);
    assign frame_wrap = (hcount == H_LAST) && (vcount == V_LAST);
    // The first pixel of a word comes straight from word_buf; shift is loaded on that same edge.
    assign pix_bit    = (sx_lo == 4'd0) ? word_buf[0] : shift[0];

    // Enable only ever rises on a frame boundary so a partly loaded VRAM never shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable <= 1'b0;
        end else if (frame_wrap && loaded) begin
            enable <= 1'b1;
        end
    end

    // Stage 0 -> 1: issue the VRAM word address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr <= BASE_ADDR;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= fetch_p0;
            if (fetch_p0) begin
                vram_addr <= BASE_ADDR + {1'b0, sy_lo, fetch_off[8:4]};
            end
        end
    end

    // Stage 1 -> 2: VRAM samples the address; data arrives during the vld_p2 cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            word_buf <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p2) begin
                word_buf <= vram_data;
            end
        end
    end

    // Stage 2 -> output: serialise LSB first; Hack ink bit 1 is black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
            pixel <= 1'b0;
        end else begin
            if (win && (sx_lo == 4'd0)) begin
                shift <= {1'b0, word_buf[DATA_W-1:1]};
            end else begin
                shift <= {1'b0, shift[DATA_W-1:1]};
            end
            pixel <= win && visible && !pix_bit;
        end
    end

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Bench for hack_screen_scanout: random VRAM image, raster-level reference model, targeted edge checks.
module tb_hack_screen_scanout;

    localparam logic [13:0] BASE  = 14'h0000;
    localparam int          X0    = 64;
    localparam int          Y0    = 40;
    localparam int          HT    = 800;
    localparam int          VT    = 525;
    localparam int          FRAME = HT * VT;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        loaded    = 1'b0;
    logic [15:0] vram_data = 16'h0000;
    logic [13:0] vram_addr;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        pixel;
    logic        frame_start;

    logic [15:0] mem [0:16383];

    int vectors     = 0;
    int miscompares = 0;

    int          cur_t  = -1;
    int          stage  = 0;
    bit          m_en   = 1'b0;
    logic [13:0] m_addr = BASE;

    int ln_hs = 0, ln_vs = 0, ln_de = 0, ln_fs = 0, ln_pix = 0, ln_addr = 0;
    int ln_white = 0, tail_white = 0;
    int fr_hs_low = 0, fr_vs_low = 0, fr_de_hi = 0, fr_white = 0, fr_fs = 0, fr_addr = 0;
    int first_white_t = -1;

    hack_screen_scanout #(
        .BASE_ADDR (BASE),
        .X0        (X0),
        .Y0        (Y0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .loaded      (loaded),
        .vram_data   (vram_data),
        .vram_addr   (vram_addr),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .pixel       (pixel),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // Synchronous-read VRAM with one cycle of latency.
    always @(posedge clk) vram_data <= mem[vram_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d stage=%0d)", tag, got, exp, cur_t, stage);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".hsync"},       32'(hsync),       32'd1);
        check_val({tag, ".vsync"},       32'(vsync),       32'd1);
        check_val({tag, ".de"},          32'(de),          32'd0);
        check_val({tag, ".pixel"},       32'(pixel),       32'd0);
        check_val({tag, ".frame_start"}, 32'(frame_start), 32'd0);
        check_val({tag, ".vram_addr"},   32'(vram_addr),   32'(BASE));
    endtask

    task automatic flush_line();
        check_val("line_hsync",     32'(ln_hs),   32'd0);
        check_val("line_vsync",     32'(ln_vs),   32'd0);
        check_val("line_de",        32'(ln_de),   32'd0);
        check_val("line_fstart",    32'(ln_fs),   32'd0);
        check_val("line_pixel",     32'(ln_pix),  32'd0);
        check_val("line_vram_addr", 32'(ln_addr), 32'd0);
        ln_hs = 0; ln_vs = 0; ln_de = 0; ln_fs = 0; ln_pix = 0; ln_addr = 0; ln_white = 0;
    endtask

    // One clock: advance the raster model at the edge, compare on the falling edge.
    task automatic step();
        int          h, v, sx, sy, foff;
        bit          win, e_pix, e_hs, e_vs, e_de, e_fs;
        logic [15:0] w;
        @(posedge clk);
        cur_t++;
        h    = cur_t % HT;
        v    = (cur_t / HT) % VT;
        sx   = h - X0;
        sy   = v - Y0;
        foff = h - (X0 - 3);
        win  = (sx >= 0) && (sx < 512) && (sy >= 0) && (sy < 256);
        e_pix = 1'b0;
        if (m_en && win && h < 640 && v < 480) begin
            w     = mem[(int'(BASE) + sy * 32 + sx / 16) % 16384];
            e_pix = !w[sx % 16];
        end
        if (m_en && sy >= 0 && sy < 256 && foff >= 0 && foff <= 496 && foff % 16 == 0)
            m_addr = 14'((int'(BASE) + sy * 32 + foff / 16) % 16384);
        e_hs = !(h >= 656 && h <= 751);
        e_vs = !(v >= 490 && v <= 491);
        e_de = (h < 640) && (v < 480);
        e_fs = (h == 0) && (v == 0);
        if (h == HT - 1 && v == VT - 1 && loaded) m_en = 1'b1;
        @(negedge clk);

        if (hsync       !== e_hs)   ln_hs++;
        if (vsync       !== e_vs)   ln_vs++;
        if (de          !== e_de)   ln_de++;
        if (frame_start !== e_fs)   ln_fs++;
        if (pixel       !== e_pix)  ln_pix++;
        if (vram_addr   !== m_addr) ln_addr++;
        if (pixel === 1'b1) begin
            ln_white++;
            if (stage == 0 && first_white_t < 0) first_white_t = cur_t;
        end
        if (stage == 0 && cur_t < FRAME) begin
            if (hsync === 1'b0) fr_hs_low++;
            if (vsync === 1'b0) fr_vs_low++;
            if (de === 1'b1) fr_de_hi++;
            if (pixel === 1'b1) fr_white++;
            if (frame_start === 1'b1) fr_fs++;
            if (vram_addr !== BASE) fr_addr++;
        end
        if (v == Y0 + 255 && sx >= 496 && sx <= 510 && pixel === 1'b1) tail_white++;

        if (cur_t == 0) check_val("fstart_first_cycle", 32'(frame_start), 32'd1);
        if (stage == 0 && cur_t >= FRAME) begin
            if (v == Y0 && h == X0)           check_val("bit0_leftmost",     32'(pixel),     32'd0);
            if (v == Y0 && h == X0 + 1)       check_val("bit1_second",       32'(pixel),     32'd1);
            if (v == Y0 && h == HT - 1) begin
                check_val("row0_white_count", 32'(ln_white), 32'd511);
                check_val("first_white_frame", 32'(first_white_t / FRAME), 32'd1);
            end
            if (v == Y0 + 1 && h == X0 - 4)   check_val("addr_hold_prev",    32'(vram_addr), 32'd31);
            if (v == Y0 + 1 && h == X0 - 3)   check_val("addr_row1_first",   32'(vram_addr), 32'd32);
            if (v == Y0 + 1 && h == X0 + 13)  check_val("addr_row1_second",  32'(vram_addr), 32'd33);
            if (v == Y0 + 1 && h == X0 + 493) check_val("addr_row1_last",    32'(vram_addr), 32'd63);
            if (v == Y0 + 255 && h == X0 - 3)   check_val("addr_row255_first", 32'(vram_addr), 32'd8160);
            if (v == Y0 + 255 && h == X0 + 493) check_val("addr_row255_last",  32'(vram_addr), 32'd8191);
            if (v == Y0 + 255 && h == X0 + 511) check_val("last_px_bit15",     32'(pixel),     32'd0);
            if (v == Y0 + 255 && h == X0 + 512) check_val("border_after_win",  32'(pixel),     32'd0);
            if (v == Y0 + 255 && h == HT - 1)   check_val("tail_15_white",     32'(tail_white), 32'd15);
        end
        if (stage == 0 && cur_t == FRAME - 1) begin
            check_val("frame_hsync_low", 32'(fr_hs_low), 32'd50400);
            check_val("frame_vsync_low", 32'(fr_vs_low), 32'd1600);
            check_val("frame_de_high",   32'(fr_de_hi),  32'd307200);
            check_val("frame_fstart",    32'(fr_fs),     32'd1);
            check_val("frame_no_white",  32'(fr_white),  32'd0);
            check_val("frame_addr_base", 32'(fr_addr),   32'd0);
        end
        if (stage == 1 && v == Y0 && h == HT - 1)
            check_val("no_pixels_after_rst", 32'(ln_white), 32'd0);
        if (h == HT - 1) flush_line();
    endtask

    task automatic run_to(input int t_end);
        while (cur_t < t_end) step();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        for (int k = 0; k < 32; k++) mem[(int'(BASE) + k) % 16384] = 16'h0000;
        mem[int'(BASE)] = 16'h0001;
        mem[(int'(BASE) + 8191) % 16384] = 16'h8000;

        repeat (4) @(negedge clk);
        check_reset_outputs("rst_init");
        rst_n = 1'b1;

        // Frame 1 stays dark: loaded rises mid-frame and only counts at the wrap.
        run_to(200 * HT + 123);
        loaded = 1'b1;
        run_to(FRAME + 300 * HT + 400);
        check_val("de_before_rst", 32'(de), 32'd1);
        flush_line();

        #5 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        stage  = 1;
        cur_t  = -1;
        m_en   = 1'b0;
        m_addr = BASE;
        rst_n  = 1'b1;
        run_to((Y0 + 2) * HT - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
